// File: rtl/wb_pipe_regs.sv
// EX/MEM and MEM/WB pipeline registers with register-file write port and load-use hazard detection.
// Optional load-use stall statistics counter enabled by defining WB_PIPE_STALL_STATS_EN.
module wb_pipe_regs #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [REG_W-1:0]  ex_wr,
    input  logic              ex_wb,
    input  logic              ex_memrd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              flush,
    input  logic [REG_W-1:0]  id_r1,
    input  logic [REG_W-1:0]  id_r2,
    output logic [REG_W-1:0]  EX_MEM_wr,
    output logic              EX_MEM_wb,
    output logic [DATA_W-1:0] EX_MEM_result,
    output logic [REG_W-1:0]  MEM_WB_wr,
    output logic              MEM_WB_wb,
    output logic [DATA_W-1:0] MEM_WB_data,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              load_use_stall,
    output logic [15:0]       stall_count
);

    logic EX_MEM_memrd;

    // NOTE: all pipeline state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            EX_MEM_wr     <= '0;
            EX_MEM_wb     <= 1'b0;
            EX_MEM_memrd  <= 1'b0;
            EX_MEM_result <= '0;
        end else if (!mem_stall) begin
            if (flush || !ex_valid) begin
                EX_MEM_wr     <= '0;
                EX_MEM_wb     <= 1'b0;
                EX_MEM_memrd  <= 1'b0;
                EX_MEM_result <= '0;
            end else begin
                EX_MEM_wr     <= ex_wr;
                EX_MEM_wb     <= ex_wb && (ex_wr != '0);  // r0 is hardwired zero
                EX_MEM_memrd  <= ex_memrd;
                EX_MEM_result <= ex_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_WB_wr   <= '0;
            MEM_WB_wb   <= 1'b0;
            MEM_WB_data <= '0;
        end else if (!mem_stall) begin
            MEM_WB_wr   <= EX_MEM_wr;
            MEM_WB_wb   <= EX_MEM_wb;
            MEM_WB_data <= EX_MEM_memrd ? mem_rdata : EX_MEM_result;
        end
    end

    // A held MEM/WB entry must write only once, on the cycle the memory releases.
    assign rf_we = MEM_WB_wb && !mem_stall;
    assign rf_wa = MEM_WB_wr;
    assign rf_wd = MEM_WB_data;

    assign load_use_stall = EX_MEM_memrd && EX_MEM_wb && (EX_MEM_wr != '0) &&
                            ((EX_MEM_wr == id_r1) || (EX_MEM_wr == id_r2));

`ifdef WB_PIPE_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (load_use_stall && !mem_stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_pipe_regs.sv
// Self-checking bench for wb_pipe_regs: directed scenarios plus randomized traffic against a stage-level model.
module tb_wb_pipe_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_wr;
    logic        ex_wb;
    logic        ex_memrd;
    logic [15:0] ex_result;
    logic [15:0] mem_rdata;
    logic        mem_stall;
    logic        flush;
    logic [3:0]  id_r1, id_r2;
    logic [3:0]  EX_MEM_wr;
    logic        EX_MEM_wb;
    logic [15:0] EX_MEM_result;
    logic [3:0]  MEM_WB_wr;
    logic        MEM_WB_wb;
    logic [15:0] MEM_WB_data;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [15:0] rf_wd;
    logic        load_use_stall;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef WB_PIPE_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    wb_pipe_regs #(.DATA_W(16), .REG_W(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_wb(ex_wb),
        .ex_memrd(ex_memrd), .ex_result(ex_result), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall), .flush(flush), .id_r1(id_r1), .id_r2(id_r2),
        .EX_MEM_wr(EX_MEM_wr), .EX_MEM_wb(EX_MEM_wb), .EX_MEM_result(EX_MEM_result),
        .MEM_WB_wr(MEM_WB_wr), .MEM_WB_wb(MEM_WB_wb), .MEM_WB_data(MEM_WB_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        ex_valid = 1'b0; ex_wr = '0; ex_wb = 1'b0; ex_memrd = 1'b0; ex_result = '0;
        mem_rdata = '0; mem_stall = 1'b0; flush = 1'b0; id_r1 = '0; id_r2 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [3:0] wr, input logic wb, input logic memrd, input logic [15:0] res);
        ex_valid = 1'b1; ex_wr = wr; ex_wb = wb; ex_memrd = memrd; ex_result = res;
    endtask

    task automatic bubble();
        ex_valid = 1'b0; ex_wr = '0; ex_wb = 1'b0; ex_memrd = 1'b0; ex_result = '0;
    endtask

    task automatic test_reset();
        logic [86:0] all_out;
        idle();
        rst = 1'b1;
        issue(4'd5, 1'b1, 1'b0, 16'h7777);
        for (int i = 0; i < 2; i++) begin
            tick();
            all_out = {EX_MEM_wr, EX_MEM_wb, EX_MEM_result, MEM_WB_wr, MEM_WB_wb, MEM_WB_data,
                       rf_we, rf_wa, rf_wd, load_use_stall, stall_count};
            n_cmp++;
            if (all_out !== '0) begin
                n_bad++;
                $display("FAIL reset_cycle%0d: outputs=%h required all zero", i, all_out);
            end
        end
        rst = 1'b0;
        bubble();
        #1;
        all_out = {EX_MEM_wr, EX_MEM_wb, EX_MEM_result, MEM_WB_wr, MEM_WB_wb, MEM_WB_data,
                   rf_we, rf_wa, rf_wd, load_use_stall, stall_count};
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_after: outputs=%h required all zero", all_out);
        end
    endtask

    task automatic test_straight_line();
        do_reset();
        issue(4'd3, 1'b1, 1'b0, 16'h1234);
        tick();
        n_cmp++;
        if ({EX_MEM_wr, EX_MEM_wb, EX_MEM_result} !== {4'd3, 1'b1, 16'h1234}) begin
            n_bad++;
            $display("FAIL straight_ex_mem: wr=%0d wb=%b res=%h required 3/1/1234", EX_MEM_wr, EX_MEM_wb, EX_MEM_result);
        end
        issue(4'd4, 1'b1, 1'b0, 16'h00FF);
        tick();
        bubble();
        #1;
        n_cmp++;
        if ({MEM_WB_data, rf_we, rf_wa, rf_wd} !== {16'h1234, 1'b1, 4'd3, 16'h1234}) begin
            n_bad++;
            $display("FAIL straight_wb_r3: data=%h we=%b wa=%0d wd=%h required 1234/1/3/1234", MEM_WB_data, rf_we, rf_wa, rf_wd);
        end
        n_cmp++;
        if (EX_MEM_wr !== 4'd4) begin
            n_bad++;
            $display("FAIL straight_ex_mem_r4: wr=%0d required 4", EX_MEM_wr);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd4, 16'h00FF}) begin
            n_bad++;
            $display("FAIL straight_wb_r4: we=%b wa=%0d wd=%h required 1/4/00ff", rf_we, rf_wa, rf_wd);
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL straight_drain: rf_we=%b required 0", rf_we);
        end
    endtask

    task automatic test_r0_suppress();
        logic seen_we;
        do_reset();
        issue(4'd0, 1'b1, 1'b0, 16'h5555);
        tick();
        bubble();
        #1;
        n_cmp++;
        if (EX_MEM_wb !== 1'b0) begin
            n_bad++;
            $display("FAIL r0_ex_mem_wb: got %b required 0", EX_MEM_wb);
        end
        seen_we = rf_we;
        tick();
        seen_we |= rf_we;
        n_cmp++;
        if (MEM_WB_wb !== 1'b0) begin
            n_bad++;
            $display("FAIL r0_mem_wb_wb: got %b required 0", MEM_WB_wb);
        end
        tick();
        seen_we |= rf_we;
        n_cmp++;
        if (seen_we !== 1'b0) begin
            n_bad++;
            $display("FAIL r0_rf_we: got %b required 0", seen_we);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id_r1 = 4'd2;
        id_r2 = 4'd7;
        issue(4'd7, 1'b1, 1'b1, 16'h0040);
        #1;
        n_cmp++;
        if (load_use_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_before: stall=%b required 0", load_use_stall);
        end
        tick();
        bubble();
        mem_rdata = 16'hBEEF;
        #1;
        n_cmp++;
        if (load_use_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL lu_in_ex_mem: stall=%b required 1", load_use_stall);
        end
        tick();
        n_cmp++;
        if ({load_use_stall, MEM_WB_data, MEM_WB_wr, rf_we} !== {1'b0, 16'hBEEF, 4'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL lu_after: stall=%b data=%h wr=%0d we=%b required 0/beef/7/1", load_use_stall, MEM_WB_data, MEM_WB_wr, rf_we);
        end
        n_cmp++;
        if (stall_count !== (STATS ? 16'd1 : 16'd0)) begin
            n_bad++;
            $display("FAIL lu_stall_count: got %0d required %0d", stall_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        id_r1 = 4'd7;
        issue(4'd2, 1'b1, 1'b0, 16'h2222);
        tick();
        issue(4'd7, 1'b1, 1'b1, 16'h0080);
        tick();
        bubble();
        mem_stall = 1'b1;
        mem_rdata = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({load_use_stall, rf_we} !== 2'b10) begin
                n_bad++;
                $display("FAIL ms_hold%0d: stall=%b we=%b required 1/0", i, load_use_stall, rf_we);
            end
            tick();
        end
        n_cmp++;
        if ({EX_MEM_wr, EX_MEM_result, MEM_WB_wr, MEM_WB_data, stall_count} !== {4'd7, 16'h0080, 4'd2, 16'h2222, 16'd0}) begin
            n_bad++;
            $display("FAIL ms_frozen: exw=%0d exr=%h mww=%0d mwd=%h cnt=%0d required 7/0080/2/2222/0",
                     EX_MEM_wr, EX_MEM_result, MEM_WB_wr, MEM_WB_data, stall_count);
        end
        mem_stall = 1'b0;
        mem_rdata = 16'hCAFE;
        #1;
        n_cmp++;
        if ({load_use_stall, rf_we, rf_wa, rf_wd} !== {1'b1, 1'b1, 4'd2, 16'h2222}) begin
            n_bad++;
            $display("FAIL ms_release: stall=%b we=%b wa=%0d wd=%h required 1/1/2/2222", load_use_stall, rf_we, rf_wa, rf_wd);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_wa, rf_wd, stall_count} !== {1'b1, 4'd7, 16'hCAFE, (STATS ? 16'd1 : 16'd0)}) begin
            n_bad++;
            $display("FAIL ms_load_write: we=%b wa=%0d wd=%h cnt=%0d", rf_we, rf_wa, rf_wd, stall_count);
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL ms_single_write: rf_we=%b required 0", rf_we);
        end
    endtask

    task automatic test_flush();
        do_reset();
        issue(4'd9, 1'b1, 1'b0, 16'hABCD);
        flush = 1'b1;
        tick();
        n_cmp++;
        if ({EX_MEM_wr, EX_MEM_wb, EX_MEM_result} !== {4'd0, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL flush_bubble: wr=%0d wb=%b res=%h required 0/0/0000", EX_MEM_wr, EX_MEM_wb, EX_MEM_result);
        end
        flush = 1'b0;
        tick();
        issue(4'd10, 1'b1, 1'b0, 16'h0BAD);
        flush = 1'b1;
        mem_stall = 1'b1;
        tick();
        n_cmp++;
        if ({EX_MEM_wr, EX_MEM_wb, EX_MEM_result} !== {4'd9, 1'b1, 16'hABCD}) begin
            n_bad++;
            $display("FAIL flush_stalled: wr=%0d wb=%b res=%h required 9/1/abcd", EX_MEM_wr, EX_MEM_wb, EX_MEM_result);
        end
        idle();
    endtask

    // Reference model: one record per occupied pipeline slot, advanced by the architectural rules.
    typedef struct {
        logic [3:0]  wr;
        logic        wb;
        logic        is_load;
        logic [15:0] val;
    } slot_t;

    task automatic test_random();
        slot_t em, mw, em_n, mw_n;
        int    cnt, cnt_n;
        logic  exp_stall;
        do_reset();
        em = '{4'd0, 1'b0, 1'b0, 16'd0};
        mw = em;
        cnt = 0;
        for (int c = 0; c < 500; c++) begin
            rst       = ($urandom_range(0, 99) < 2);
            ex_valid  = ($urandom_range(0, 3) != 0);
            ex_wr     = 4'($urandom_range(0, 15));
            ex_wb     = ($urandom_range(0, 4) != 0);
            ex_memrd  = ($urandom_range(0, 2) == 0);
            ex_result = 16'($urandom);
            mem_rdata = 16'($urandom);
            mem_stall = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            id_r1     = ($urandom_range(0, 1) == 1) ? em.wr : 4'($urandom_range(0, 15));
            id_r2     = 4'($urandom_range(0, 15));
            #1;
            exp_stall = em.is_load && em.wb && (em.wr != 0) && (em.wr == id_r1 || em.wr == id_r2);
            n_cmp++;
            if ({load_use_stall, rf_we, rf_wa, rf_wd} !== {exp_stall, mw.wb && !mem_stall, mw.wr, mw.val}) begin
                n_bad++;
                $display("FAIL rand_comb c=%0d: stall=%b we=%b wa=%0d wd=%h required %b/%b/%0d/%h",
                         c, load_use_stall, rf_we, rf_wa, rf_wd, exp_stall, mw.wb && !mem_stall, mw.wr, mw.val);
            end
            em_n = em; mw_n = mw; cnt_n = cnt;
            if (rst) begin
                em_n = '{4'd0, 1'b0, 1'b0, 16'd0};
                mw_n = em_n;
                cnt_n = 0;
            end else if (!mem_stall) begin
                mw_n = '{em.wr, em.wb, 1'b0, em.is_load ? mem_rdata : em.val};
                if (flush || !ex_valid) em_n = '{4'd0, 1'b0, 1'b0, 16'd0};
                else em_n = '{ex_wr, ex_wb && (ex_wr != 0), ex_memrd, ex_result};
                if (STATS && exp_stall && cnt < 65535) cnt_n = cnt + 1;
            end
            tick();
            em = em_n; mw = mw_n; cnt = cnt_n;
            n_cmp++;
            if ({EX_MEM_wr, EX_MEM_wb, EX_MEM_result, MEM_WB_wr, MEM_WB_wb, MEM_WB_data, stall_count} !==
                {em.wr, em.wb, em.val, mw.wr, mw.wb, mw.val, 16'(cnt)}) begin
                n_bad++;
                $display("FAIL rand_regs c=%0d: ex=%0d/%b/%h mw=%0d/%b/%h cnt=%0d required ex=%0d/%b/%h mw=%0d/%b/%h cnt=%0d",
                         c, EX_MEM_wr, EX_MEM_wb, EX_MEM_result, MEM_WB_wr, MEM_WB_wb, MEM_WB_data, stall_count,
                         em.wr, em.wb, em.val, mw.wr, mw.wb, mw.val, cnt);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #2;
        test_reset();
        test_straight_line();
        test_r0_suppress();
        test_load_use();
        test_mem_stall();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_pipe_regs.md
Name: wb_pipe_regs

Overview:
- EX/MEM and MEM/WB pipeline registers for the 16-register pipelined core.
- Directly upstream of the forwarding unit: produces its EX_MEM_wr/EX_MEM_wb/MEM_WB_wr/MEM_WB_wb inputs.
- Also drives the register-file write port.
- Detects load-use hazards against the registers read in ID and requests a one-cycle stall, because load data only exists at MEM/WB.

Parameters:
- DATA_W, 16, width of ALU result / memory read data / writeback data.
- REG_W, 4, register-address width; r0 is hardwired zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX stage holds a real instruction (0 = bubble).
- ex_wr  input  REG_W  destination register of EX instruction.
- ex_wb  input  1  EX instruction writes back.
- ex_memrd  input  1  EX instruction is a load.
- ex_result  input  DATA_W  ALU result / load address from EX.
- mem_rdata  input  DATA_W  data-memory read data for the instruction in EX/MEM, valid in the same cycle.
- mem_stall  input  1  data memory busy; freeze both stages.
- flush  input  1  squash the instruction entering EX/MEM.
- id_r1, id_r2  input  REG_W  source registers of the instruction in ID.
- EX_MEM_wr  output  REG_W  EX/MEM destination register.
- EX_MEM_wb  output  1  EX/MEM writeback enable.
- EX_MEM_result  output  DATA_W  EX/MEM ALU result (EX forwarding path).
- MEM_WB_wr  output  REG_W  MEM/WB destination register.
- MEM_WB_wb  output  1  MEM/WB writeback enable.
- MEM_WB_data  output  DATA_W  MEM/WB writeback data (MEM forwarding path).
- rf_we  output  1  register-file write enable.
- rf_wa  output  REG_W  register-file write address.
- rf_wd  output  DATA_W  register-file write data.
- load_use_stall  output  1  hold IF/ID and send a bubble into EX.
- stall_count  output  16  load-use stall counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at clk edge): all registered outputs and internal state cleared to 0, including EX_MEM_memrd and stall_count. Overrides mem_stall and flush.
- EX/MEM update priority each edge: rst > mem_stall (hold all fields) > flush (load bubble) > capture.
  - Bubble means wr=0, wb=0, memrd=0, result=0.
  - Capture loads ex_* fields.
  - ex_valid=0 captures a bubble.
  - ex_wb is forced to 0 when ex_wr==0, so r0 is never written.
- MEM/WB update: rst > mem_stall (hold) > capture.
  - Capture: MEM_WB_wr<=EX_MEM_wr; MEM_WB_wb<=EX_MEM_wb.
  - MEM_WB_data<=EX_MEM_memrd ? mem_rdata : EX_MEM_result.
- Latency: ex_* to EX_MEM_* is 1 cycle; to MEM_WB_* and rf_* is 2 cycles, plus any mem_stall cycles.
- rf_we = MEM_WB_wb & ~mem_stall; rf_wa = MEM_WB_wr; rf_wd = MEM_WB_data (combinational). A held MEM/WB entry therefore writes exactly once, on the cycle mem_stall drops.
- load_use_stall (combinational) = EX_MEM_memrd & EX_MEM_wb & (EX_MEM_wr!=0) & (EX_MEM_wr==id_r1 | EX_MEM_wr==id_r2).
  - Normally high for exactly one cycle, since the load advances to MEM/WB next edge.
  - Stays high for as long as mem_stall freezes the load.
- load_use_stall does not alter this block's registers; upstream supplies the bubble via ex_valid=0.
- flush with mem_stall high is ignored; upstream holds flush until mem_stall drops.
- Back-to-back writes to the same register: both proceed in order. The forwarding unit prefers EX/MEM, so the newest value wins.

Optional Feature:
- Macro: WB_PIPE_STALL_STATS_EN.
- Defined: stall_count increments by 1 on each rising edge where load_use_stall=1 and mem_stall=0. It saturates at 16'hFFFF and is cleared by rst.
- Undefined: stall_count is tied to 16'h0000, and no counter logic is built.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_valid=1, ex_wb=1, ex_wr=5 -> every output 0 during reset and on the cycle after.
- Straight-line: ADD to r3, result 16'h1234, then r4 with 16'h00FF on consecutive cycles.
  - Expect EX_MEM_wr=3/wb=1 at +1 and MEM_WB_data=16'h1234 at +2.
  - Expect rf_we=1, rf_wa=3, rf_wd=16'h1234 at +2, then r4/16'h00FF at +3.
- r0 suppression: ex_wr=0, ex_wb=1 -> EX_MEM_wb=0, MEM_WB_wb=0, rf_we never asserts.
- Load-use: load to r7 (ex_memrd=1) with id_r2=7.
  - load_use_stall=1 for exactly the cycle the load sits in EX/MEM.
  - MEM_WB_data = mem_rdata (16'hBEEF) next cycle; stall_count=1 with WB_PIPE_STALL_STATS_EN, 0 without.
- mem_stall for 3 cycles with the load in EX/MEM and id_r1=7: registers hold; load_use_stall stays high all 3 cycles; rf_we=0 throughout; a single write occurs after release.
- Flush: flush=1 with ex_valid=1, ex_wr=9 -> EX_MEM_wb=0, EX_MEM_wr=0 next cycle. Repeat with mem_stall=1 -> EX/MEM unchanged.
